// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with a per-register pending scoreboard.
//
// After reset the block walks every register once (CLEAR), loading register 2
// with SP_INIT and all others with zero, then enters READY. In READY it
// provides two combinational read ports with optional write-to-read
// forwarding. It also tracks a pending bit per register: a reserve marks the
// register as awaiting a result, and a writeback clears that mark.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset (restarts CLEAR)
//   write_en     in   writeback strobe (ignored in CLEAR)
//   write_addr   in   writeback register index
//   write_value  in   writeback data
//   rsv_en       in   reserve strobe (ignored in CLEAR)
//   rsv_addr     in   register index to mark pending
//   rs1_addr     in   read port 1 index
//   rs2_addr     in   read port 2 index
//   rs1_data     out  read port 1 data (combinational)
//   rs2_data     out  read port 2 data (combinational)
//   rs1_pend     out  read port 1 operand not yet available
//   rs2_pend     out  read port 2 operand not yet available
//   ready        out  high once the clear sequence has completed

module reg_file_sb #(
  parameter int              XLEN    = 32,
  parameter int              NREG    = 32,
  parameter logic [XLEN-1:0] SP_INIT = {XLEN{1'b0}},
  parameter bit              BYPASS  = 1'b1,
  localparam int             AW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            write_en,
  input  logic [AW-1:0]   write_addr,
  input  logic [XLEN-1:0] write_value,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_pend,
  output logic            rs2_pend,
  output logic            ready
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};
  localparam logic [AW-1:0] SP_IDX   = AW'(2);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_t            state_r;
  state_t            state_s;
  logic [AW-1:0]     clr_idx_r;
  logic [AW-1:0]     clr_idx_s;
  logic [XLEN-1:0]   regs_r [NREG];
  logic [NREG-1:0]   pend_r;
  logic [NREG-1:0]   pend_s;

  logic              wr_en_s;
  logic [AW-1:0]     wr_addr_s;
  logic [XLEN-1:0]   wr_data_s;
  logic              user_wr_s;

  logic              hit1_s;
  logic              hit2_s;

  // A writeback from the pipeline only counts in READY and never for x0.
  always_comb begin
    user_wr_s = 1'b0;
    if ((state_r == READY) && write_en && (write_addr != ZERO_IDX)) begin
      user_wr_s = 1'b1;
    end else begin
      user_wr_s = 1'b0;
    end
  end

  // Next-state and clear-index logic.
  always_comb begin
    state_s   = state_r;
    clr_idx_s = clr_idx_r;
    case (state_r)
      CLEAR: begin
        if (clr_idx_r == LAST_IDX) begin
          state_s   = READY;
          clr_idx_s = ZERO_IDX;
        end else begin
          state_s   = CLEAR;
          clr_idx_s = clr_idx_r + AW'(1);
        end
      end
      READY: begin
        state_s   = READY;
        clr_idx_s = ZERO_IDX;
      end
      default: begin
        state_s   = CLEAR;
        clr_idx_s = ZERO_IDX;
      end
    endcase
  end

  // State and clear-index registers; reset restarts the clear walk at index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= CLEAR;
      clr_idx_r <= ZERO_IDX;
    end else begin
      state_r   <= state_s;
      clr_idx_r <= clr_idx_s;
    end
  end

  // Single storage write port: the clear walk in CLEAR, pipeline writeback in READY.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = ZERO_IDX;
    wr_data_s = {XLEN{1'b0}};
    if (reset) begin
      wr_en_s = 1'b0;
    end else if (state_r == CLEAR) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clr_idx_r;
      wr_data_s = (clr_idx_r == SP_IDX) ? SP_INIT : {XLEN{1'b0}};
    end else begin
      wr_en_s   = user_wr_s;
      wr_addr_s = write_addr;
      wr_data_s = write_value;
    end
  end

  // Register storage; contents come only from the clear walk or writebacks.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      regs_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Scoreboard update: write clears first, then reserve sets, so reserve wins.
  always_comb begin
    pend_s = pend_r;
    if (state_r == READY) begin
      if (write_en) begin
        pend_s[write_addr] = 1'b0;
      end else begin
        pend_s = pend_s;
      end
      if (rsv_en && (rsv_addr != ZERO_IDX)) begin
        pend_s[rsv_addr] = 1'b1;
      end else begin
        pend_s = pend_s;
      end
    end else begin
      pend_s = pend_r;
    end
    pend_s[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r <= {NREG{1'b0}};
    end else begin
      pend_r <= pend_s;
    end
  end

  // Forwarding hits: a same-cycle writeback to the index being read.
  always_comb begin
    hit1_s = 1'b0;
    hit2_s = 1'b0;
    if (BYPASS && user_wr_s) begin
      hit1_s = (write_addr == rs1_addr);
      hit2_s = (write_addr == rs2_addr);
    end else begin
      hit1_s = 1'b0;
      hit2_s = 1'b0;
    end
  end

  // Read port 1: zero in CLEAR and for x0, forwarded value on a bypass hit.
  always_comb begin
    rs1_data = {XLEN{1'b0}};
    rs1_pend = 1'b0;
    if ((state_r != READY) || (rs1_addr == ZERO_IDX)) begin
      rs1_data = {XLEN{1'b0}};
      rs1_pend = 1'b0;
    end else if (hit1_s) begin
      rs1_data = write_value;
      rs1_pend = 1'b0;
    end else begin
      rs1_data = regs_r[rs1_addr];
      rs1_pend = pend_r[rs1_addr];
    end
  end

  // Read port 2: identical to port 1, fully independent.
  always_comb begin
    rs2_data = {XLEN{1'b0}};
    rs2_pend = 1'b0;
    if ((state_r != READY) || (rs2_addr == ZERO_IDX)) begin
      rs2_data = {XLEN{1'b0}};
      rs2_pend = 1'b0;
    end else if (hit2_s) begin
      rs2_data = write_value;
      rs2_pend = 1'b0;
    end else begin
      rs2_data = regs_r[rs2_addr];
      rs2_pend = pend_r[rs2_addr];
    end
  end

  // Ready is a direct decode of the state register.
  always_comb begin
    ready = 1'b0;
    if (state_r == READY) begin
      ready = 1'b1;
    end else begin
      ready = 1'b0;
    end
  end

  reg_file_sb_chk #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .pend0    (pend_r[0])
  );

endmodule

// reg_file_sb_chk: invariants of the register file sampled on each rising edge.
//
// Ports: clk, reset, ready, rs1/rs2 address, data and pend (observed), and
// pend0 (scoreboard bit of x0). All inputs.
module reg_file_sb_chk #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input logic            clk,
  input logic            reset,
  input logic            ready,
  input logic [AW-1:0]   rs1_addr,
  input logic [AW-1:0]   rs2_addr,
  input logic [XLEN-1:0] rs1_data,
  input logic [XLEN-1:0] rs2_data,
  input logic            rs1_pend,
  input logic            rs2_pend,
  input logic            pend0
);

  // Outputs stay quiet during clear, x0 always reads as 0, x0 is never pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (ready || ((rs1_data == {XLEN{1'b0}}) && (rs2_data == {XLEN{1'b0}})
                        && !rs1_pend && !rs2_pend));
      assert ((rs1_addr != {AW{1'b0}}) || ((rs1_data == {XLEN{1'b0}}) && !rs1_pend));
      assert ((rs2_addr != {AW{1'b0}}) || ((rs2_data == {XLEN{1'b0}}) && !rs2_pend));
      assert (!pend0);
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed bench for reg_file_sb. Two instances share all
// inputs: dut forwards writes to reads, dut_nb does not. Inputs change 1 ns
// after each rising edge; outputs are checked 1 ns after that.
module tb_reg_file_sb;

  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            write_en;
  logic [AW-1:0]   write_addr;
  logic [31:0]     write_value;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [31:0]     rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
  logic            rs1_pend, rs2_pend, nb_rs1_pend, nb_rs2_pend;
  logic            ready, nb_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(32), .NREG(32), .SP_INIT(32'h0000_1000), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .write_en(write_en), .write_addr(write_addr),
    .write_value(write_value), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_pend(rs1_pend), .rs2_pend(rs2_pend), .ready(ready)
  );

  reg_file_sb #(.XLEN(32), .NREG(32), .SP_INIT(32'h0000_1000), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .write_en(write_en), .write_addr(write_addr),
    .write_value(write_value), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
    .rs1_pend(nb_rs1_pend), .rs2_pend(nb_rs2_pend), .ready(nb_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs may be changed on return.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Count edges until ready rises, bounded so a stuck DUT cannot hang the run.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      cyc();
      n++;
    end
  endtask

  task automatic idle();
    write_en = 1'b0; write_addr = 5'd0; write_value = 32'h0;
    rsv_en = 1'b0; rsv_addr = 5'd0;
  endtask

  initial begin
    idle();
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;

    // Clear phase: outputs quiet, strobes on x3 must be ignored.
    rs1_addr = 5'd2; rs2_addr = 5'd2;
    write_en = 1'b1; write_addr = 5'd3; write_value = 32'hAAAA_5555;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    #1;
    check("clr_ready", {63'd0, ready}, 64'd0);
    check("clr_rs1_data", {32'd0, rs1_data}, 64'd0);
    check("clr_rs1_pend", {63'd0, rs1_pend}, 64'd0);
    wait_ready(n_cyc);
    idle();
    check("clr_cycles", 64'(n_cyc), 64'd32);
    check("nb_ready", {63'd0, nb_ready}, 64'd1);

    // Contents after clear.
    rs1_addr = 5'd2; rs2_addr = 5'd5;
    #1;
    check("x2_sp_init", {32'd0, rs1_data}, 64'h1000);
    check("x5_zero", {32'd0, rs2_data}, 64'd0);
    rs1_addr = 5'd3; rs2_addr = 5'd3;
    #1;
    check("x3_ignored_data", {32'd0, rs1_data}, 64'd0);
    check("x3_ignored_pend", {63'd0, rs2_pend}, 64'd0);

    // Plain write, then both ports on the same index.
    write_en = 1'b1; write_addr = 5'd5; write_value = 32'hDEAD_BEEF;
    cyc();
    idle();
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    #1;
    check("x5_rs1", {32'd0, rs1_data}, 64'hDEAD_BEEF);
    check("x5_rs2", {32'd0, rs2_data}, 64'hDEAD_BEEF);

    // x0 writes are discarded.
    write_en = 1'b1; write_addr = 5'd0; write_value = 32'hFFFF_FFFF;
    cyc();
    idle();
    rs2_addr = 5'd0;
    #1;
    check("x0_data", {32'd0, rs2_data}, 64'd0);
    check("x0_pend", {63'd0, rs2_pend}, 64'd0);

    // Bypass: reserve x7, then write it while reading it in the same cycle.
    rsv_en = 1'b1; rsv_addr = 5'd7;
    cyc();
    idle();
    rs1_addr = 5'd7;
    write_en = 1'b1; write_addr = 5'd7; write_value = 32'h1234_5678;
    #1;
    check("byp_data", {32'd0, rs1_data}, 64'h1234_5678);
    check("byp_pend", {63'd0, rs1_pend}, 64'd0);
    check("nobyp_data", {32'd0, nb_rs1_data}, 64'd0);
    check("nobyp_pend", {63'd0, nb_rs1_pend}, 64'd1);
    cyc();
    idle();
    #1;
    check("x7_after", {32'd0, nb_rs1_data}, 64'h1234_5678);
    check("x7_pend_clr", {63'd0, nb_rs1_pend}, 64'd0);

    // Scoreboard: reserve, reserve+write (reserve wins), lone write clears.
    rsv_en = 1'b1; rsv_addr = 5'd9;
    cyc();
    idle();
    rs1_addr = 5'd9;
    #1;
    check("x9_rsv", {63'd0, rs1_pend}, 64'd1);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    write_en = 1'b1; write_addr = 5'd9; write_value = 32'h0000_0055;
    cyc();
    idle();
    #1;
    check("x9_rsv_wins", {63'd0, rs1_pend}, 64'd1);
    check("x9_data55", {32'd0, rs1_data}, 64'h55);
    write_en = 1'b1; write_addr = 5'd9; write_value = 32'h0000_0066;
    cyc();
    idle();
    #1;
    check("x9_wr_clears", {63'd0, rs1_pend}, 64'd0);
    check("x9_data66", {32'd0, rs1_data}, 64'h66);

    // Reserve and write on different registers in one cycle.
    rsv_en = 1'b1; rsv_addr = 5'd10;
    write_en = 1'b1; write_addr = 5'd11; write_value = 32'h0000_0077;
    cyc();
    idle();
    rs1_addr = 5'd10; rs2_addr = 5'd11;
    #1;
    check("x10_pend", {63'd0, rs1_pend}, 64'd1);
    check("x11_data", {32'd0, rs2_data}, 64'h77);
    check("x11_pend", {63'd0, rs2_pend}, 64'd0);

    // Reset from READY, then again at clr_idx 10 held two cycles.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    check("mid_ready", {63'd0, ready}, 64'd0);
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    wait_ready(n_cyc);
    check("reclr_cycles", 64'(n_cyc), 64'd32);
    rs1_addr = 5'd5; rs2_addr = 5'd9;
    #1;
    check("x5_wiped", {32'd0, rs1_data}, 64'd0);
    check("x9_wiped", {32'd0, rs2_data}, 64'd0);
    rs1_addr = 5'd10; rs2_addr = 5'd2;
    #1;
    check("x10_pend_wiped", {63'd0, rs1_pend}, 64'd0);
    check("x2_reinit", {32'd0, rs2_data}, 64'h1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
